// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// Outputs are registered; tx_start/req_ready assert the cycle after START.
//
// state | meaning
// IDLE  | no transfer; sample req_valid, pick winner, latch byte
// START | one cycle; next edge raises tx_start and req_ready[grant]
// WAIT  | transmitter busy; wait for tx_done or timeout
// GAP   | enforced idle spacing before next arbitration

module uart_tx_arb #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [3:0]  i_req_valid,
   input  logic [31:0] i_req_data,
   output logic [3:0]  o_req_ready,
   output logic        o_tx_start,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_done,
   output logic        o_busy,
   output logic [1:0]  o_grant_id,
   output logic        o_timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t      r_state;
   logic [1:0]  r_ptr;
   logic [23:0] r_wait_cnt;
   logic [7:0]  r_gap_cnt;
   logic [3:0]  r_req_ready;
   logic        r_tx_start;
   logic [7:0]  r_tx_data;
   logic        r_busy;
   logic [1:0]  r_grant_id;
   logic        r_timeout_err;

   logic [1:0]  w_winner;
   logic [1:0]  w_idx;
   logic        w_any;
   logic [7:0]  w_win_data;

   // Scan from ptr+3 down to ptr so the requester closest to ptr wins.
   always_comb begin
      w_winner = r_ptr;
      w_idx    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (i_req_valid[w_idx]) w_winner = w_idx;
      end
   end

   assign w_any      = |i_req_valid;
   assign w_win_data = i_req_data[{w_winner, 3'b000} +: 8];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_ptr         <= 2'd0;
         r_wait_cnt    <= 24'd0;
         r_gap_cnt     <= 8'd0;
         r_req_ready   <= 4'd0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= 8'd0;
         r_busy        <= 1'b0;
         r_grant_id    <= 2'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_tx_start    <= 1'b0;
         r_req_ready   <= 4'd0;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state    <= S_START;
                  r_grant_id <= w_winner;
                  r_tx_data  <= w_win_data;
                  r_ptr      <= w_winner + 2'd1;
                  r_busy     <= 1'b1;
               end
            end
            S_START: begin
               r_tx_start              <= 1'b1;
               r_req_ready[r_grant_id] <= 1'b1;
               r_wait_cnt              <= 24'd0;
               r_state                 <= S_WAIT;
            end
            S_WAIT: begin
               if (i_tx_done) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= GAP_LAST;
               end else if (r_wait_cnt == TO_LAST) begin
                  // Byte is dropped, not retried; requester already got its accept.
                  r_timeout_err <= 1'b1;
                  r_state       <= S_GAP;
                  r_gap_cnt     <= GAP_LAST;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 24'd1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == 8'd0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_tx_start    = r_tx_start;
   assign o_tx_data     = r_tx_data;
   assign o_busy        = r_busy;
   assign o_grant_id    = r_grant_id;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.

module tb_uart_tx_arb;

   localparam int GAP = 2;
   localparam int TMO = 16;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [3:0]  i_req_valid = 4'd0;
   logic [31:0] i_req_data = 32'd0;
   logic        i_tx_done = 1'b0;
   logic [3:0]  o_req_ready;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic        o_busy;
   logic [1:0]  o_grant_id;
   logic        o_timeout_err;

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;
   logic [3:0] pend = 4'd0;
   logic [7:0] data [4];

   uart_tx_arb #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_req_valid   (i_req_valid),
      .i_req_data    (i_req_data),
      .o_req_ready   (o_req_ready),
      .o_tx_start    (o_tx_start),
      .o_tx_data     (o_tx_data),
      .i_tx_done     (i_tx_done),
      .o_busy        (o_busy),
      .o_grant_id    (o_grant_id),
      .o_timeout_err (o_timeout_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr(input int p, input logic [3:0] v);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4] == 1'b1) return (p + k) % 4;
      return 0;
   endfunction

   task automatic drive_reqs();
      i_req_valid = pend;
      i_req_data  = {data[3], data[2], data[1], data[0]};
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(o_busy), 32'd0);
      chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
      chk({tag, "_data"},  32'(o_tx_data), 32'd0);
      chk({tag, "_ready"}, 32'(o_req_ready), 32'd0);
      chk({tag, "_grant"}, 32'(o_grant_id), 32'd0);
      chk({tag, "_tmo"},   32'(o_timeout_err), 32'd0);
   endtask

   task automatic do_reset();
      i_reset     = 1'b1;
      i_req_valid = 4'd0;
      i_tx_done   = 1'b0;
      pend        = 4'd0;
      tick();
      chk_all_zero("rst");
      i_reset = 1'b0;
      exp_ptr = 0;
      tick();
      chk("rst_release_busy", 32'(o_busy), 32'd0);
   endtask

   // One full transaction starting from IDLE; dk = edge index (after the
   // sampling edge) at which tx_done is seen, or timeout when to=1.
   task automatic serve(input bit to, input int dk, output int w);
      int g;
      w = rr(exp_ptr, pend);
      chk("idle_busy", 32'(o_busy), 32'd0);
      drive_reqs();
      i_tx_done = 1'($urandom_range(0, 1));
      tick();
      chk("start_busy",   32'(o_busy), 32'd1);
      chk("start_latency", 32'(o_tx_start), 32'd0);
      chk("start_grant",  32'(o_grant_id), 32'(w));
      chk("start_data",   32'(o_tx_data), 32'(data[w]));
      i_tx_done = 1'($urandom_range(0, 1));
      tick();
      chk("txs_start", 32'(o_tx_start), 32'd1);
      chk("txs_ready", 32'(o_req_ready), 32'd1 << w);
      chk("txs_grant", 32'(o_grant_id), 32'(w));
      chk("txs_data",  32'(o_tx_data), 32'(data[w]));
      i_tx_done = 1'b0;
      exp_ptr = (w + 1) % 4;
      tick();
      chk("wait_start", 32'(o_tx_start), 32'd0);
      chk("wait_ready", 32'(o_req_ready), 32'd0);
      g = to ? TMO + 1 : dk;
      for (int k = 3; k <= g; k++) begin
         i_tx_done = (!to && k == g);
         tick();
         i_tx_done = 1'b0;
         chk("wait_tmo",   32'(o_timeout_err), 32'(to && k == g));
         chk("wait_grant", 32'(o_grant_id), 32'(w));
         chk("wait_data",  32'(o_tx_data), 32'(data[w]));
         chk("wait_busy",  32'(o_busy), 32'd1);
      end
      for (int p = 0; p < 4; p++)
         if (!pend[p] && $urandom_range(0, 1) == 1) i_req_valid[p] = 1'b1;
      for (int c = 1; c < GAP; c++) begin
         i_tx_done = 1'($urandom_range(0, 1));
         tick();
         chk("gap_busy",  32'(o_busy), 32'd1);
         chk("gap_start", 32'(o_tx_start), 32'd0);
         chk("gap_tmo",   32'(o_timeout_err), 32'd0);
      end
      i_tx_done = 1'($urandom_range(0, 1));
      tick();
      i_tx_done = 1'b0;
      chk("gap_end_busy",  32'(o_busy), 32'd0);
      chk("gap_end_start", 32'(o_tx_start), 32'd0);
      drive_reqs();
   endtask

   initial begin
      int w;
      bit to;
      for (int i = 0; i < 4; i++) data[i] = 8'd0;

      // Reset held: all outputs zero
      tick();
      chk_all_zero("por");
      do_reset();

      // Single requester 0, byte 55
      pend = 4'b0001; data[0] = 8'h55;
      serve(1'b0, 4, w);
      pend = 4'b0000; drive_reqs();
      tick();
      chk("idle_hold_busy", 32'(o_busy), 32'd0);

      // Requesters 0 and 2 held: alternate 0,2,0,2
      do_reset();
      pend = 4'b0101; data[0] = 8'hAA; data[2] = 8'hF0;
      for (int n = 0; n < 4; n++) serve(1'b0, 3 + n, w);

      // All four: grants 0,1,2,3, each dropping after its accept
      do_reset();
      pend = 4'b1111;
      data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
      for (int n = 0; n < 4; n++) begin
         serve(1'b0, 5, w);
         pend[w] = 1'b0;
      end

      // Timeout on requester 0, then requester 1 served normally
      do_reset();
      pend = 4'b0011; data[0] = 8'h3C; data[1] = 8'hC3;
      serve(1'b1, 0, w);
      pend[w] = 1'b0;
      serve(1'b0, 6, w);
      pend[w] = 1'b0;

      // Reset 5 cycles into WAIT after ptr has advanced
      do_reset();
      pend = 4'b0010; data[1] = 8'h5A;
      serve(1'b0, 4, w);
      pend = 4'b0100; data[2] = 8'hA5;
      drive_reqs();
      for (int n = 0; n < 7; n++) tick();
      chk("pre_rst_busy", 32'(o_busy), 32'd1);
      #2 i_reset = 1'b1;
      #1 chk_all_zero("async_rst");
      i_req_valid = 4'd0;
      tick();
      tick();
      chk_all_zero("rst_hold");
      i_reset = 1'b0;
      exp_ptr = 0;
      pend = 4'b1001; data[0] = 8'h01; data[3] = 8'h08;
      tick();
      serve(1'b0, 4, w);
      pend = 4'b1000;
      serve(1'b0, 4, w);
      pend = 4'b0000; drive_reqs();

      // Randomized traffic
      do_reset();
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               data[i] = 8'($urandom);
            end
         if (pend == 4'd0) begin
            int i = int'($urandom_range(0, 3));
            pend[i] = 1'b1;
            data[i] = 8'($urandom);
         end
         to = ($urandom_range(0, 7) == 0);
         serve(to, int'($urandom_range(3, 12)), w);
         if ($urandom_range(0, 2) != 0) pend[w] = 1'b0;
         else data[w] = 8'($urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, idle cycles enforced between a tx_done and the next tx_start (range 1-255).
REQ-002 Parameter: TIMEOUT_CYCLES, default 100000, maximum WAIT cycles allowed before tx_done (range 1 to 2^24-1).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  in  4  requester i has a byte pending.
REQ-006 Port: req_data  in  32  requester i byte at bits [8i+7:8i].
REQ-007 Port: req_ready  out  4  one-cycle accept pulse to requester i.
REQ-008 Port: tx_start  out  1  start pulse to the shared uart_tx.
REQ-009 Port: tx_data  out  8  byte presented to uart_tx data_in.
REQ-010 Port: tx_done  in  1  completion indication from uart_tx.
REQ-011 Port: busy  out  1  high in any state other than IDLE.
REQ-012 Port: grant_id  out  2  index of the requester currently owning the transmitter.
REQ-013 Port: timeout_err  out  1  one-cycle pulse on tx_done timeout.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, GAP, all outputs registered.
REQ-015 IDLE: if any req_valid is high at a rising edge, the FSM SHALL select the winner by round-robin from priority pointer ptr, latch its byte into tx_data, set grant_id, and move to START.
REQ-016 Round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); after a grant ptr SHALL become winner+1 mod 4.
REQ-017 START lasts exactly one cycle, with tx_start=1 and req_ready[grant_id]=1; all other req_ready bits SHALL be 0.
REQ-018 A transfer completes at the edge where req_valid[i] and req_ready[i] are both high; requesters hold req_data stable while req_valid is high until then.
REQ-019 Latency: req_valid seen in IDLE at edge N -> tx_start high between edges N+1 and N+2.
REQ-020 WAIT: tx_data and grant_id SHALL stay constant; a 24-bit counter increments each cycle; tx_done=1 SHALL move to GAP.
REQ-021 tx_done SHALL be ignored in IDLE, START and GAP.
REQ-022 If the WAIT counter reaches TIMEOUT_CYCLES without tx_done, timeout_err SHALL pulse for one cycle and the FSM SHALL move to GAP; that byte is not retried.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then the FSM SHALL return to IDLE; req_valid is not sampled during GAP.
REQ-024 A requester that deasserts req_valid before its grant SHALL be skipped with no side effect.
REQ-025 A requester reasserting after its grant SHALL wait behind all other pending requesters (no back-to-back grant while others pend).
REQ-026 busy SHALL be 0 only in IDLE.

Reset
REQ-027 While reset=1, asynchronously: state=IDLE, ptr=0, tx_start=0, tx_data=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, counters=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the in-flight byte with no req_ready or timeout_err pulse; after release the FSM SHALL be in IDLE.

Verification
REQ-029 After reset, req_valid=4'b0001, req_data[7:0]=8'h55 -> tx_start one cycle one edge later, tx_data=8'h55, req_ready=4'b0001, grant_id=0; tx_done -> GAP for 2 cycles -> IDLE.
REQ-030 req_valid=4'b0101 held, data 8'hAA (req 0) and 8'hF0 (req 2) -> grant order 0, 2, 0, 2 with tx_data AA, F0, AA, F0.
REQ-031 All four valid, bytes 8'h11/22/33/44 -> grants 0,1,2,3 in order; tx_start never within 2 cycles of a tx_done.
REQ-032 TIMEOUT_CYCLES=16, tx_done held 0 -> timeout_err one-cycle pulse 16 cycles after entering WAIT; next pending requester is served after GAP.
REQ-033 reset asserted 5 cycles into WAIT -> all outputs 0 immediately; after release, req_valid=4'b1000 gets grant_id=3 with ptr having restarted at 0.
REQ-034 tx_done pulsed during IDLE and START -> no state change; only a tx_done in WAIT ends the transfer.
